// File: rtl/avmm_pkg.sv
// Shared constants, state encoding and sizing helpers for the Avalon-MM wait-state slave.
package avmm_pkg;

    // Avalon-MM response codes
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Handshake FSM encoding
    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t WAIT = 2'd1;
    localparam state_t ACK  = 2'd2;

    // Number of byte lanes in a DW-bit word
    function automatic int byte_lanes(input int dw);
        return dw / 8;
    endfunction

    // Width of a word index into a DEPTH-entry register file
    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/avmm_regfile.sv
// DEPTH x DW register storage: async clear, per-byte write strobes, combinational read.
module avmm_regfile
    import avmm_pkg::*;
#(
    parameter int DW    = 32,
    parameter int DEPTH = 16,
    parameter int IW    = idx_width(DEPTH),
    parameter int NB    = byte_lanes(DW)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [IW-1:0] addr,
    input  logic [NB-1:0] wr_be,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DEPTH-1:0][DW-1:0] mem;

    // One write port per byte lane; the caller only strobes lanes for in-range words
    for (genvar b = 0; b < NB; b++) begin : g_lane
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                for (int w = 0; w < DEPTH; w++) mem[w][b*8 +: 8] <= '0;
            end else if (wr_be[b]) begin
                mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/avmm_wait_slave.sv
// Avalon-MM slave register file with programmable wait states and error responses.
module avmm_wait_slave
    import avmm_pkg::*;
#(
    parameter int AW          = 8,
    parameter int DW          = 32,
    parameter int DEPTH       = 16,
    parameter int WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [AW-1:0]     address,
    input  logic [DW/8-1:0]   byteenable,
    input  logic              read,
    input  logic              write,
    input  logic [DW-1:0]     writedata,
    output logic              waitrequest,
    output logic [DW-1:0]     readdata,
    output logic [1:0]        response
);

    localparam int            NB      = byte_lanes(DW);
    localparam int            IW      = idx_width(DEPTH);
    localparam logic [AW:0]   DEPTH_C = DEPTH[AW:0];
    localparam logic [7:0]    WS_M1   = 8'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    state_t        state, state_nxt;
    logic [7:0]    cnt, cnt_nxt;
    logic          cmd, in_range, wr_ok;
    logic [NB-1:0] wr_be;
    logic [DW-1:0] rf_rdata;

    assign cmd      = read | write;
    assign in_range = {1'b0, address} < DEPTH_C;
    assign wr_ok    = write & ~read & in_range;
    // Address is not latched: the commit uses whatever the master holds in ACK
    assign wr_be    = (state == ACK && wr_ok) ? byteenable : '0;

    avmm_regfile #(.DW(DW), .DEPTH(DEPTH), .IW(IW), .NB(NB)) u_rf (
        .clk     (clk),
        .reset_n (reset_n),
        .addr    (address[IW-1:0]),
        .wr_be   (wr_be),
        .wdata   (writedata),
        .rdata   (rf_rdata)
    );

    // Next-state and wait counter; a dropped command in WAIT abandons the transfer
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: if (cmd) begin
                if (WAIT_STATES == 0) begin
                    state_nxt = ACK;
                end else begin
                    state_nxt = WAIT;
                    cnt_nxt   = WS_M1;
                end
            end
            WAIT: begin
                if (!cmd)          state_nxt = IDLE;
                else if (cnt == 0) state_nxt = ACK;
                else               cnt_nxt   = cnt - 8'd1;
            end
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State and counter registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Registered outputs; readdata/response are decoded on ACK entry and held until the next one
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            waitrequest <= 1'b1;
            readdata    <= '0;
            response    <= RESP_OKAY;
        end else begin
            waitrequest <= (state_nxt != ACK);
            if (state_nxt == ACK) begin
                if (!in_range) begin
                    response <= RESP_DECERR;
                    readdata <= '0;
                end else if (read && write) begin
                    response <= RESP_SLVERR;
                    readdata <= '0;
                end else if (read) begin
                    response <= RESP_OKAY;
                    readdata <= rf_rdata;
                end else begin
                    response <= RESP_OKAY;
                    readdata <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_avmm_wait_slave.sv
// Randomized bench for avmm_wait_slave: one instance with 2 wait states, one with none.
module tb_avmm_wait_slave;

    localparam int AW    = 8;
    localparam int DW    = 32;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    logic            read [2];
    logic            write [2];
    logic [AW-1:0]   address [2];
    logic [3:0]      byteenable [2];
    logic [DW-1:0]   writedata [2];
    logic            waitrequest [2];
    logic [DW-1:0]   readdata [2];
    logic [1:0]      response [2];

    avmm_wait_slave #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .WAIT_STATES(2)) u_dut (
        .clk(clk), .reset_n(reset_n), .address(address[0]), .byteenable(byteenable[0]),
        .read(read[0]), .write(write[0]), .writedata(writedata[0]),
        .waitrequest(waitrequest[0]), .readdata(readdata[0]), .response(response[0])
    );

    avmm_wait_slave #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .address(address[1]), .byteenable(byteenable[1]),
        .read(read[1]), .write(write[1]), .writedata(writedata[1]),
        .waitrequest(waitrequest[1]), .readdata(readdata[1]), .response(response[1])
    );

    int npass = 0;
    int ntot  = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural model: register contents plus the one expected accept per instance
    logic [DW-1:0] mem [2][DEPTH];
    bit            active [2];
    int            ack_cyc [2];
    logic [DW-1:0] exp_rd [2];
    logic [1:0]    exp_resp [2];
    logic [DW-1:0] last_rd [2];
    logic [1:0]    last_resp [2];
    bit            chk_en = 1'b0;

    function automatic int ws(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    function automatic bit is_ack(input int d);
        return active[d] && (cyc == ack_cyc[d]);
    endfunction

    // Per-cycle compare of all outputs against the model
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!reset_n) begin
                last_rd[d]   <= '0;
                last_resp[d] <= 2'b00;
            end else if (chk_en) begin
                chk($sformatf("waitrequest[%0d] cyc %0d", d, cyc), {31'b0, waitrequest[d]}, {31'b0, !is_ack(d)});
                chk($sformatf("readdata[%0d] cyc %0d", d, cyc), readdata[d], is_ack(d) ? exp_rd[d] : last_rd[d]);
                chk($sformatf("response[%0d] cyc %0d", d, cyc), {30'b0, response[d]},
                    {30'b0, is_ack(d) ? exp_resp[d] : last_resp[d]});
                if (is_ack(d)) begin
                    last_rd[d]   <= exp_rd[d];
                    last_resp[d] <= exp_resp[d];
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #2;
        end
    endtask

    // One complete transfer; called 2 time units after a falling edge
    task automatic xfer(input int d, input bit r, input bit w, input int a, input logic [31:0] wd,
                        input logic [3:0] be, output logic [31:0] got_rd, output logic [1:0] got_resp);
        read[d] = r; write[d] = w; address[d] = AW'(a); writedata[d] = wd; byteenable[d] = be;
        if (a >= DEPTH)      begin exp_resp[d] = 2'b11; exp_rd[d] = '0; end
        else if (r && w)     begin exp_resp[d] = 2'b10; exp_rd[d] = '0; end
        else if (r)          begin exp_resp[d] = 2'b00; exp_rd[d] = mem[d][a]; end
        else                 begin exp_resp[d] = 2'b00; exp_rd[d] = '0; end
        ack_cyc[d] = cyc + ws(d) + 1;
        active[d]  = 1'b1;
        repeat (ws(d) + 1) @(negedge clk);
        #1;
        got_rd   = readdata[d];
        got_resp = response[d];
        @(negedge clk);
        #2;
        read[d] = 1'b0; write[d] = 1'b0;
        active[d] = 1'b0;
        if (w && !r && a < DEPTH)
            for (int b = 0; b < 4; b++)
                if (be[b]) mem[d][a][b*8 +: 8] = wd[b*8 +: 8];
    endtask

    logic [31:0] g;
    logic [1:0]  gr;

    initial begin
        for (int d = 0; d < 2; d++) begin
            read[d] = 0; write[d] = 0; address[d] = '0; byteenable[d] = '0; writedata[d] = '0;
            for (int i = 0; i < DEPTH; i++) mem[d][i] = '0;
        end
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("reset waitrequest", {31'b0, waitrequest[d]}, 32'd1);
            chk("reset readdata", readdata[d], 32'd0);
            chk("reset response", {30'b0, response[d]}, 32'd0);
        end
        @(negedge clk); #2;
        reset_n = 1'b1;
        chk_en  = 1'b1;
        step(1);

        // Write then read back, exact latency checked by the compare process
        xfer(0, 0, 1, 10, 32'h14, 4'hF, g, gr);
        xfer(0, 1, 0, 10, 32'h0, 4'h0, g, gr);
        chk("rd a10 data", g, 32'h0000_0014);
        chk("rd a10 resp", {30'b0, gr}, 32'd0);

        // Partial byte-enable merge
        xfer(0, 0, 1, 5, 32'hAABBCCDD, 4'hF, g, gr);
        xfer(0, 0, 1, 5, 32'h11223344, 4'h5, g, gr);
        xfer(0, 1, 0, 5, 32'h0, 4'h0, g, gr);
        chk("byte merge a5", g, 32'hAA22CC44);

        // Out-of-range accesses
        xfer(0, 1, 0, 20, 32'h0, 4'h0, g, gr);
        chk("oor rd resp", {30'b0, gr}, 32'd3);
        chk("oor rd data", g, 32'd0);
        xfer(0, 0, 1, 20, 32'hFFFF_FFFF, 4'hF, g, gr);
        chk("oor wr resp", {30'b0, gr}, 32'd3);
        for (int i = 0; i < DEPTH; i++) xfer(0, 1, 0, i, 32'h0, 4'h0, g, gr);

        // Read and write together is a slave error with no side effect
        xfer(0, 0, 1, 3, 32'h12345678, 4'hF, g, gr);
        xfer(0, 1, 1, 3, 32'h0, 4'hF, g, gr);
        chk("rw resp", {30'b0, gr}, 32'd2);
        xfer(0, 1, 0, 3, 32'h0, 4'h0, g, gr);
        chk("rw a3 kept", g, 32'h12345678);

        // Zero-wait instance, back-to-back reads
        xfer(1, 0, 1, 1, 32'h0101_0101, 4'hF, g, gr);
        xfer(1, 0, 1, 2, 32'h0202_0202, 4'hF, g, gr);
        xfer(1, 1, 0, 1, 32'h0, 4'h0, g, gr);
        chk("ws0 rd a1", g, 32'h0101_0101);
        xfer(1, 1, 0, 2, 32'h0, 4'h0, g, gr);
        chk("ws0 rd a2", g, 32'h0202_0202);

        // Zero byteenable write is OKAY and changes nothing
        xfer(1, 0, 1, 2, 32'hDEAD_BEEF, 4'h0, g, gr);
        chk("be0 resp", {30'b0, gr}, 32'd0);
        xfer(1, 1, 0, 2, 32'h0, 4'h0, g, gr);
        chk("be0 a2 kept", g, 32'h0202_0202);

        // Command dropped during WAIT: no accept, no write
        read[0] = 0; write[0] = 1; address[0] = 8'd6; writedata[0] = 32'h6666_6666; byteenable[0] = 4'hF;
        step(1);
        write[0] = 0;
        step(4);
        xfer(0, 1, 0, 6, 32'h0, 4'h0, g, gr);
        chk("drop a6 kept", g, 32'd0);

        // Randomized traffic on both instances
        for (int i = 0; i < 120; i++) begin
            int d, k, a;
            bit r, w;
            d = $urandom_range(0, 1);
            k = $urandom_range(0, 9);
            r = (k == 0) || (k < 5);
            w = (k == 0) || (k >= 5);
            a = (r && w) ? $urandom_range(0, DEPTH - 1) : $urandom_range(0, DEPTH + 7);
            xfer(d, r, w, a, $urandom, 4'($urandom_range(0, 15)), g, gr);
            step($urandom_range(0, 2));
        end
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < DEPTH; i++) xfer(d, 1, 0, i, 32'h0, 4'h0, g, gr);

        // Reset mid-transfer: instance 0 in WAIT, instance 1 in ACK
        xfer(0, 0, 1, 4, 32'hDEAD_0004, 4'hF, g, gr);
        xfer(1, 0, 1, 2, 32'h0000_CAFE, 4'hF, g, gr);
        chk_en = 1'b0;
        read[0] = 0; write[0] = 1; address[0] = 8'd4; writedata[0] = 32'h55; byteenable[0] = 4'hF;
        read[1] = 1; write[1] = 0; address[1] = 8'd2;
        step(1);
        chk("pre-reset ws0 ack", {31'b0, waitrequest[1]}, 32'd0);
        chk("pre-reset ws0 data", readdata[1], 32'h0000_CAFE);
        reset_n = 1'b0;
        #1;
        chk("async rst waitreq0", {31'b0, waitrequest[0]}, 32'd1);
        chk("async rst waitreq1", {31'b0, waitrequest[1]}, 32'd1);
        chk("async rst readdata1", readdata[1], 32'd0);
        read[1] = 0; write[0] = 0;
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < DEPTH; i++) mem[d][i] = '0;
        step(2);
        reset_n = 1'b1;
        step(1);
        chk_en = 1'b1;
        xfer(0, 1, 0, 4, 32'h0, 4'h0, g, gr);
        chk("a4 cleared by reset", g, 32'd0);
        xfer(1, 1, 0, 2, 32'h0, 4'h0, g, gr);
        chk("ws0 a2 cleared", g, 32'd0);
        step(2);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule

// File: doc/avmm_wait_slave.md
Name: avmm_wait_slave

Overview:
- Parametrised Avalon-MM slave: a register file with byte-enable writes and a configurable number of wait states, signalled through waitrequest.
- It is the endpoint used to exercise master read/write tasks and to stand in for slow peripherals on the interconnect.
- It adds three things to the basic always-waitrequest handshake: a wait-state counter, per-byte writes, and an error response for out-of-range or illegal accesses.

Parameters:
- AW, 8, address width in words.
- DW, 32, data width; must be a multiple of 8.
- DEPTH, 16, number of DW-bit registers; must satisfy 1..2**AW.
- WAIT_STATES, 2, number of cycles with waitrequest held high after a command is sampled, before the accept cycle; range 0..255.

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset; asynchronous, active-low.
- address  in  AW  word address.
- byteenable  in  DW/8  write byte lanes.
- read  in  1  read command.
- write  in  1  write command.
- writedata  in  DW  write data.
- waitrequest  out  1  high = command not yet accepted.
- readdata  out  DW  read data; valid while waitrequest is low on a read.
- response  out  2  00 OKAY, 10 SLVERR, 11 DECODEERROR; valid while waitrequest is low.

Behaviour:
- Reset (asynchronous): state IDLE, waitrequest=1, readdata=0, response=00, wait counter=0, all DEPTH registers=0.
- All outputs are registered. Commands are sampled on the rising edge of clk.
- State machine, 3 states: IDLE, WAIT, ACK. waitrequest is 0 only in ACK.
- IDLE:
  - read|write sampled: if WAIT_STATES=0 go to ACK, else go to WAIT with counter=WAIT_STATES-1.
  - No command: stay in IDLE.
- WAIT:
  - Command dropped: go to IDLE, no side effects.
  - Counter=0: go to ACK.
  - Otherwise decrement the counter.
- Latency: WAIT_STATES+1 edges from the command-sample edge to the first edge with waitrequest low.
- On entry to ACK, decode the current address and command:
  - read only, address<DEPTH: readdata=reg[address], response=00.
  - write only, address<DEPTH: response=00, readdata=0.
  - address>=DEPTH: response=11, readdata=0.
  - read and write both high: response=10, readdata=0.
- ACK, commit edge (command still high):
  - Valid write: reg[address] lane i takes writedata lane i for each i with byteenable[i]=1.
  - Error cases: no register changes.
  - Next state: IDLE, so waitrequest returns to 1 and the slave holds off at least one cycle between transfers.
- ACK, command dropped before the commit edge: no write, go to IDLE. This is a master protocol violation and is tolerated.
- Leaving ACK: readdata and response keep their values until the next ACK entry.
- address, writedata and byteenable must be stable from command assertion through ACK. The address is re-read at commit and is not latched.
- Reset mid-transfer: return to IDLE immediately, no commit, registers cleared.
- byteenable=0 on a write: response=00, no register change.

Decomposition:
- Package avmm_pkg:
  - response code constants RESP_OKAY, RESP_SLVERR, RESP_DECERR.
  - state typedef {IDLE, WAIT, ACK}.
  - function computing the byte-lane count from DW.
- Sub-module avmm_regfile: DEPTH x DW storage with async-reset clear, per-byte write enable and a combinational read port. The top-level holds the FSM, counter, decode and output registers.

Test Plan:
- WAIT_STATES=2: write addr 10, data 0x14, byteenable 0xF, then read addr 10 -> waitrequest low exactly 3 edges after each command sample, readdata=0x00000014, response=00.
- Write 0xAABBCCDD to addr 5, then write 0x11223344 to addr 5 with byteenable 0x5, then read addr 5 -> readdata=0xAA22CC44.
- DEPTH=16: read addr 20 -> response=11, readdata=0. Write addr 20 -> response=11, and a sweep of registers 0..15 shows no change.
- read and write both high on addr 3 -> response=10, reg[3] unchanged.
- WAIT_STATES=0: back-to-back reads of addr 1 and 2 -> waitrequest low on the first edge after the sample, then high for at least one cycle between the two accepts.
- Assert reset_n=0 during WAIT of a write of 0x55 to addr 4 -> waitrequest=1 immediately, reg[4]=0 after reset is released.
